// File: rtl/tt_stim_pkg.sv
// Shared types and constants for the tt_um_* stimulus driver.
// Entry layout: {ui, uio, expected uo, compare mask}.
package tt_stim_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_e;

    localparam int UI_MSB   = 31;
    localparam int UI_LSB   = 24;
    localparam int UIO_MSB  = 23;
    localparam int UIO_LSB  = 16;
    localparam int EXP_MSB  = 15;
    localparam int EXP_LSB  = 8;
    localparam int MASK_MSB = 7;
    localparam int MASK_LSB = 0;

    localparam logic [7:0] ERR_MAX   = 8'd255;
    localparam logic [7:0] IDLE_UI   = 8'h00;
    localparam logic [7:0] IDLE_UIO  = 8'h00;
    localparam logic       IDLE_ENA  = 1'b0;
    localparam logic       IDLE_RSTN = 1'b0;

    function automatic logic entry_miss(
        input logic [31:0] e,
        input logic [7:0]  uo
    );
        return |((uo ^ e[EXP_MSB:EXP_LSB]) & e[MASK_MSB:MASK_LSB]);
    endfunction

endpackage

// File: rtl/tt_stim_driver_if.sv
// Pin bundle between the stimulus driver and the tt_um_* design.
// The driver is the master; the user design is the slave.
interface tt_stim_driver_if;

    logic [7:0] dut_ui_in;
    logic [7:0] dut_uio_in;
    logic       dut_ena;
    logic       dut_rst_n;
    logic [7:0] dut_uo_out;

    modport master (
        output dut_ui_in,
        output dut_uio_in,
        output dut_ena,
        output dut_rst_n,
        input  dut_uo_out
    );

    modport slave (
        input  dut_ui_in,
        input  dut_uio_in,
        input  dut_ena,
        input  dut_rst_n,
        output dut_uo_out
    );

endinterface

// File: rtl/tt_stim_mem.sv
// Stimulus table: synchronous write, registered read.
// Contents are deliberately not reset.
module tt_stim_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tt_stim_driver.sv
// Replays a stimulus table into a tt_um_* design and checks
// its masked uo_out, reporting pass, error count and first failure.
module tt_stim_driver
    import tt_stim_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int RST_CYCLES = 4,
    parameter int SETTLE     = 2,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [AW:0]            num_entries,
    input  logic                   load_we,
    input  logic [AW-1:0]          load_addr,
    input  logic [31:0]            load_data,
    tt_stim_driver_if.master       dut,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [7:0]             err_count,
    output logic [AW-1:0]          fail_idx,
    output logic [7:0]             fail_uo
);

    localparam int CMAX = (RST_CYCLES > SETTLE) ? RST_CYCLES : SETTLE;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [AW:0] NMAX = (AW + 1)'(DEPTH);
    localparam logic [AW:0] NONE = (AW + 1)'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [AW:0]   num_q, num_d;
    logic [7:0]    ui_q, ui_d;
    logic [7:0]    uio_q, uio_d;
    logic          ena_q, ena_d;
    logic          rstn_q, rstn_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [7:0]    err_q, err_d;
    logic [AW-1:0] fidx_q, fidx_d;
    logic [7:0]    fuo_q, fuo_d;
    logic [31:0]   rdata;
    logic          rd_en;
    logic          last;
    logic          miss;

    // Read for the next entry is issued whenever APPLY is next,
    // so the registered read data is ready during APPLY.
    tt_stim_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (load_we & ~busy_q),
        .waddr_i (load_addr),
        .wdata_i (load_data),
        .re_i    (rd_en),
        .raddr_i (idx_d),
        .rdata_o (rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        num_d   = num_q;
        ui_d    = ui_q;
        uio_d   = uio_q;
        ena_d   = ena_q;
        rstn_d  = rstn_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        fuo_d   = fuo_q;
        miss    = entry_miss(rdata, dut.dut_uo_out);
        last    = ({1'b0, idx_q} == num_q - NONE);
        if (abort) begin
            state_d = S_IDLE;
            ui_d    = IDLE_UI;
            uio_d   = IDLE_UIO;
            ena_d   = IDLE_ENA;
            rstn_d  = IDLE_RSTN;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_RESET;
                        cnt_d   = '0;
                        num_d   = (num_entries > NMAX) ? NMAX : num_entries;
                        err_d   = '0;
                        fidx_d  = '0;
                        fuo_d   = '0;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                        busy_d  = 1'b1;
                        ena_d   = 1'b1;
                        rstn_d  = 1'b0;
                        ui_d    = IDLE_UI;
                        uio_d   = IDLE_UIO;
                    end
                end
                S_RESET: begin
                    if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        rstn_d = 1'b1;
                        idx_d  = '0;
                        if (num_q == '0) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            pass_d  = 1'b1;
                        end else begin
                            state_d = S_APPLY;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_APPLY: begin
                    ui_d    = rdata[UI_MSB:UI_LSB];
                    uio_d   = rdata[UIO_MSB:UIO_LSB];
                    cnt_d   = '0;
                    state_d = (SETTLE > 1) ? S_SETTLE : S_CHECK;
                end
                S_SETTLE: begin
                    if (cnt_q == CW'(SETTLE - 2)) begin
                        state_d = S_CHECK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_CHECK: begin
                    if (miss) begin
                        if (err_q != ERR_MAX) begin
                            err_d = err_q + 8'd1;
                        end
                        if (err_q == '0) begin
                            fidx_d = idx_q;
                            fuo_d  = dut.dut_uo_out;
                        end
                    end
                    if (last) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d   = idx_q + AW'(1);
                        state_d = S_APPLY;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        rd_en = (state_d == S_APPLY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            num_q   <= '0;
            ui_q    <= IDLE_UI;
            uio_q   <= IDLE_UIO;
            ena_q   <= IDLE_ENA;
            rstn_q  <= IDLE_RSTN;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fidx_q  <= '0;
            fuo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
            ui_q    <= ui_d;
            uio_q   <= uio_d;
            ena_q   <= ena_d;
            rstn_q  <= rstn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            fuo_q   <= fuo_d;
        end
    end

    assign dut.dut_ui_in  = ui_q;
    assign dut.dut_uio_in = uio_q;
    assign dut.dut_ena    = ena_q;
    assign dut.dut_rst_n  = rstn_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign fail_idx       = fidx_q;
    assign fail_uo        = fuo_q;

endmodule

// File: tb/tb_tt_stim_driver.sv
// Bench for tt_stim_driver with a registered ui_in+1 loopback design.
// A second 256-deep build exercises error-count saturation.
module tb_tt_stim_driver;
    import tt_stim_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start, abort, load_we;
    logic [4:0]  num_entries;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic        busy, done, pass;
    logic [7:0]  err_count, fail_uo;
    logic [3:0]  fail_idx;
    tt_stim_driver_if bus();

    always_ff @(posedge clk) bus.dut_uo_out <= bus.dut_ui_in + 8'd1;

    tt_stim_driver dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_entries(num_entries), .load_we(load_we),
        .load_addr(load_addr), .load_data(load_data), .dut(bus),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .fail_idx(fail_idx), .fail_uo(fail_uo)
    );

    logic        start_b, abort_b, load_we_b;
    logic [8:0]  num_b;
    logic [7:0]  load_addr_b;
    logic [31:0] load_data_b;
    logic        busy_b, done_b, pass_b;
    logic [7:0]  err_b, fuo_b, fidx_b;
    tt_stim_driver_if bus_b();

    always_ff @(posedge clk) bus_b.dut_uo_out <= bus_b.dut_ui_in + 8'd1;

    tt_stim_driver #(.DEPTH(256)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .num_entries(num_b), .load_we(load_we_b),
        .load_addr(load_addr_b), .load_data(load_data_b), .dut(bus_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_idx(fidx_b), .fail_uo(fuo_b)
    );

    typedef struct {
        logic       pass;
        logic [7:0] err;
        logic [7:0] fidx;
        logic [7:0] fuo;
        int         lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] tab[16];
    int          n_checks = 0;
    int          n_fail = 0;

    // Reference: loopback answers ui+1; entries beyond 16 are clamped.
    function automatic exp_t model(input int n_in);
        exp_t       e;
        int         n;
        logic [7:0] uo;
        n = (n_in > 16) ? 16 : n_in;
        e.pass = 1'b1;
        e.err = 8'd0;
        e.fidx = 8'd0;
        e.fuo = 8'd0;
        for (int i = 0; i < n; i++) begin
            uo = tab[i][31:24] + 8'd1;
            if (((uo ^ tab[i][15:8]) & tab[i][7:0]) != 8'd0) begin
                if (e.err == 8'd0) begin
                    e.fidx = 8'(i);
                    e.fuo = uo;
                end
                if (e.err != 8'd255) e.err = e.err + 8'd1;
                e.pass = 1'b0;
            end
        end
        e.lat = 4 + n * 3 + 1;
        return e;
    endfunction

    task automatic load(input int a, input logic [31:0] d);
        @(negedge clk);
        load_we = 1'b1;
        load_addr = 4'(a);
        load_data = d;
        tab[a] = d;
        @(negedge clk);
        load_we = 1'b0;
    endtask

    task automatic run(input logic [4:0] n, output int cyc);
        @(negedge clk);
        start = 1'b1;
        num_entries = n;
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end while (!done && cyc < 400);
    endtask

    task automatic test_reset();
        n_checks++;
        if ({bus.dut_ui_in, bus.dut_uio_in, bus.dut_ena,
             bus.dut_rst_n} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_drive got %h/%h/%b/%b want 0",
                     bus.dut_ui_in, bus.dut_uio_in,
                     bus.dut_ena, bus.dut_rst_n);
        end
        n_checks++;
        if ({busy, done, pass, err_count, fail_idx, fail_uo}
            !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_status got %b%b%b %h %h %h want 0",
                     busy, done, pass, err_count, fail_idx, fail_uo);
        end
    endtask

    task automatic test_run(input string name, input logic [4:0] n);
        exp_t e;
        int   cyc;
        sb.push_back(model(int'(n)));
        run(n, cyc);
        e = sb.pop_front();
        n_checks++;
        if (!done || cyc != e.lat) begin
            n_fail++;
            $display("FAIL %s_latency done=%b got %0d want %0d",
                     name, done, cyc, e.lat);
        end
        n_checks++;
        if (pass !== e.pass || err_count !== e.err) begin
            n_fail++;
            $display("FAIL %s_result pass=%b err=%0d want %b/%0d",
                     name, pass, err_count, e.pass, e.err);
        end
        n_checks++;
        if ({4'd0, fail_idx} !== e.fidx || fail_uo !== e.fuo) begin
            n_fail++;
            $display("FAIL %s_first idx=%0d uo=%h want %0d/%h",
                     name, fail_idx, fail_uo, e.fidx, e.fuo);
        end
    endtask

    task automatic test_zero_entries();
        int lows = 0;
        int k = 0;
        @(negedge clk);
        start = 1'b1;
        num_entries = 5'd0;
        do begin
            @(negedge clk);
            start = 1'b0;
            k++;
            if (bus.dut_ena && !bus.dut_rst_n) lows++;
        end while (!done && k < 50);
        n_checks++;
        if (lows != 4) begin
            n_fail++;
            $display("FAIL zero_rst_len got %0d want 4", lows);
        end
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || bus.dut_ui_in !== 8'h00
            || bus.dut_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done d=%b p=%b ui=%h rn=%b want 1/1/00/1",
                     done, pass, bus.dut_ui_in, bus.dut_rst_n);
        end
    endtask

    task automatic test_abort_ignored();
        @(negedge clk);
        start = 1'b1;
        num_entries = 5'd4;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            start = (k == 3);
            load_we = (k == 3);
            load_addr = 4'd0;
            load_data = 32'hDEAD_BEEF;
        end
        n_checks++;
        if (bus.dut_ui_in !== tab[1][31:24] || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL run_progress ui=%h busy=%b want %h/1",
                     bus.dut_ui_in, busy, tab[1][31:24]);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (bus.dut_ena !== 1'b0 || bus.dut_rst_n !== 1'b0
            || busy !== 1'b0 || done !== 1'b0
            || bus.dut_ui_in !== 8'h00) begin
            n_fail++;
            $display("FAIL abort_idle ena=%b rn=%b b=%b d=%b ui=%h want 0",
                     bus.dut_ena, bus.dut_rst_n, busy, done,
                     bus.dut_ui_in);
        end
    endtask

    task automatic test_async_rst();
        @(negedge clk);
        start = 1'b1;
        num_entries = 5'd4;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_checks++;
        if (busy !== 1'b1 || bus.dut_ena !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_rst busy=%b ena=%b want 1/1",
                     busy, bus.dut_ena);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || bus.dut_ena !== 1'b0
            || bus.dut_rst_n !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst b=%b ena=%b rn=%b d=%b want 0",
                     busy, bus.dut_ena, bus.dut_rst_n, done);
        end
        #1 rst = 1'b0;
    endtask

    task automatic test_saturation();
        exp_t e;
        int   cyc = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            load_we_b = 1'b1;
            load_addr_b = 8'(i);
            load_data_b = {8'(i), 8'h00, 8'(i + 2), 8'hFF};
        end
        @(negedge clk);
        load_we_b = 1'b0;
        e.pass = 1'b0;
        e.err = 8'd255;
        e.fidx = 8'd0;
        e.fuo = 8'd1;
        e.lat = 4 + 256 * 3 + 1;
        sb.push_back(e);
        start_b = 1'b1;
        num_b = 9'd256;
        do begin
            @(negedge clk);
            start_b = 1'b0;
            cyc++;
        end while (!done_b && cyc < 2000);
        e = sb.pop_front();
        n_checks++;
        if (!done_b || cyc != e.lat) begin
            n_fail++;
            $display("FAIL sat_latency done=%b got %0d want %0d",
                     done_b, cyc, e.lat);
        end
        n_checks++;
        if (err_b !== e.err || pass_b !== e.pass
            || fidx_b !== e.fidx || fuo_b !== e.fuo) begin
            n_fail++;
            $display("FAIL sat_result err=%0d p=%b idx=%0d uo=%h want %0d/%b/%0d/%h",
                     err_b, pass_b, fidx_b, fuo_b,
                     e.err, e.pass, e.fidx, e.fuo);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        load_we = 1'b0;
        num_entries = '0;
        load_addr = '0;
        load_data = '0;
        start_b = 1'b0;
        abort_b = 1'b0;
        load_we_b = 1'b0;
        num_b = '0;
        load_addr_b = '0;
        load_data_b = '0;
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;

        load(0, 32'h00_00_01_FF);
        load(1, 32'h10_00_11_FF);
        load(2, 32'h7F_00_80_FF);
        load(3, 32'hFE_00_FF_FF);
        test_run("loopback", 5'd4);

        load(2, 32'h7F_00_81_FF);
        test_run("mismatch", 5'd4);
        load(2, 32'h7F_00_81_FE);
        test_run("masked", 5'd4);

        test_zero_entries();
        test_abort_ignored();
        test_run("after_abort", 5'd4);

        test_async_rst();
        test_run("after_rst", 5'd4);

        for (int i = 4; i < 16; i++) begin
            load(i, {8'(i * 13), 8'(i), 8'(i * 13 + 1), 8'hFF});
        end
        load(9, {8'h40, 8'h00, 8'hC1, 8'h7F});
        test_run("clamp", 5'd31);

        test_saturation();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
